// File: rtl/seven_seg_display_driver.sv
// Drives a 4-digit multiplexed common-anode 7-segment display from a 16-bit word.
// New words are latched as pending and only shown from the next frame start, so a frame never mixes two words.
module seven_seg_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       digit;
  logic [15:0]      shown;
  logic [15:0]      pend_reg;
  logic             slot_end;
  logic             frame_end;
  logic [3:0]       nibble;
  logic             blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit == 2'd3);
  assign dp        = 1'b1;

  // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    nibble = shown[{digit, 2'b00} +: 4];
    blank  = 1'b0;
    if (BLANK_LZ) begin
      case (digit)
        2'd1:    blank = (shown[15:4]  == '0);
        2'd2:    blank = (shown[15:8]  == '0);
        2'd3:    blank = (shown[15:12] == '0);
        default: blank = 1'b0;
      endcase
    end
    seg_next = blank ? 7'h7F : hex_font(nibble);
    // Anodes stay dark for the first cycle of each slot so the previous digit does not ghost.
    an_next  = (div_cnt == '0) ? 4'hF : ~(4'b0001 << digit);
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values;
  // this is what makes a strobe on the boundary cycle hand the OLD pend_reg to shown.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt  <= '0;
      digit    <= 2'd0;
      shown    <= 16'h0000;
      pend_reg <= 16'h0000;
      pending  <= 1'b0;
      an       <= 4'hF;
      seg      <= 7'h7F;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      if (slot_end) begin
        div_cnt <= '0;
        digit   <= digit + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (frame_end && pending) begin
        shown   <= pend_reg;
        pending <= 1'b0;
      end
      // A fresh strobe wins over the boundary clear, keeping the new word pending.
      if (data_valid) begin
        pend_reg <= data_in;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Self-checking bench: two lockstep instances (no blanking / blanking) checked frame by frame
// against a table of expected segment patterns, fed through a scoreboard queue.
module tb_seven_seg_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        data_valid = 1'b0;
  logic [3:0]  an, an_lz;
  logic [6:0]  seg, seg_lz;
  logic        dp, dp_lz;
  logic        pending, pending_lz;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [15:0]     word;
    logic [3:0][6:0] exp0;  // BLANK_LZ=0, index = digit
    logic [3:0][6:0] exp1;  // BLANK_LZ=1
  } vec_t;

  vec_t vecs [9];
  int   sb_q [$];

  always #5 clk = ~clk;

  seven_seg_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .an(an), .seg(seg), .dp(dp), .pending(pending)
  );

  seven_seg_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut_lz (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .an(an_lz), .seg(seg_lz), .dp(dp_lz), .pending(pending_lz)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pending_fall(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (pending === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " pending cleared at boundary"}, 16'(ok), 16'd1);
  endtask

  // Called at a negedge; data_valid is high across exactly one posedge.
  task automatic strobe(input logic [15:0] w);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic check_next_frame();
    int         idx;
    bit         ok;
    logic [3:0] tgt;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard: frame check with no expected word queued");
      return;
    end
    idx = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      tgt = ~(4'b0001 << k);
      wait_an(tgt, ok);
      check($sformatf("word %h digit %0d anode reached", vecs[idx].word, k), 16'(ok), 16'd1);
      check($sformatf("word %h digit %0d seg", vecs[idx].word, k), 16'(seg), 16'(vecs[idx].exp0[k]));
      check($sformatf("word %h digit %0d seg (blank lz)", vecs[idx].word, k), 16'(seg_lz),
            16'(vecs[idx].exp1[k]));
      check($sformatf("word %h digit %0d anode (blank lz)", vecs[idx].word, k), 16'(an_lz), 16'(tgt));
      check("dp off", 16'(dp), 16'd1);
    end
  endtask

  // Strobe a table word mid-frame, then expect it from the next frame boundary.
  task automatic apply(input int idx);
    bit ok;
    wait_an(4'b1101, ok);
    check("reach slot 1 before strobe", 16'(ok), 16'd1);
    strobe(vecs[idx].word);
    sb_q.push_back(idx);
    check($sformatf("word %h pending after strobe", vecs[idx].word), 16'(pending), 16'd1);
    wait_pending_fall($sformatf("word %h", vecs[idx].word));
    check_next_frame();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vecs[0] = '{16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[1] = '{16'h12AF, {7'h79, 7'h24, 7'h08, 7'h0E}, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[2] = '{16'hCDE9, {7'h46, 7'h21, 7'h06, 7'h10}, {7'h46, 7'h21, 7'h06, 7'h10}};
    vecs[3] = '{16'h3478, {7'h30, 7'h19, 7'h78, 7'h00}, {7'h30, 7'h19, 7'h78, 7'h00}};
    vecs[4] = '{16'h0B60, {7'h40, 7'h03, 7'h02, 7'h40}, {7'h7F, 7'h03, 7'h02, 7'h40}};
    vecs[5] = '{16'h0030, {7'h40, 7'h40, 7'h30, 7'h40}, {7'h7F, 7'h7F, 7'h30, 7'h40}};
    vecs[6] = '{16'h2222, {7'h24, 7'h24, 7'h24, 7'h24}, {7'h24, 7'h24, 7'h24, 7'h24}};
    vecs[7] = '{16'h0005, {7'h40, 7'h40, 7'h40, 7'h12}, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[8] = '{16'h00C0, {7'h40, 7'h40, 7'h46, 7'h40}, {7'h7F, 7'h7F, 7'h46, 7'h40}};

    // Reset held for three edges: everything dark.
    repeat (3) @(negedge clk);
    check("reset an", 16'(an), 16'hF);
    check("reset seg", 16'(seg), 16'h7F);
    check("reset dp", 16'(dp), 16'd1);
    check("reset pending", 16'(pending), 16'd0);
    reset = 1'b1;
    @(negedge clk);
    check("release guard an", 16'(an), 16'hF);
    check("release guard seg", 16'(seg), 16'h40);
    @(negedge clk);
    check("release slot0 an", 16'(an), 16'hE);
    check("release slot0 seg", 16'(seg), 16'h40);
    sb_q.push_back(0);
    check_next_frame();

    // Table-driven words, covering the whole font and both blanking cases.
    for (int i = 1; i <= 5; i++) apply(i);
    apply(0);

    // Two strobes in one frame: only the last one is ever displayed.
    wait_an(4'b1101, ok);
    check("reach slot 1 for double strobe", 16'(ok), 16'd1);
    strobe(16'h1111);
    strobe(16'h2222);
    sb_q.push_back(6);
    wait_pending_fall("double strobe");
    check_next_frame();
    sb_q.push_back(6);
    check_next_frame();

    // Strobe on the exact boundary cycle while 0005 is already pending.
    wait_an(4'b1011, ok);
    check("reach slot 2 for boundary test", 16'(ok), 16'd1);
    strobe(16'h0005);
    sb_q.push_back(7);
    wait_an(4'b0111, ok);  // state now div_cnt=2, digit=3
    check("reach slot 3 for boundary test", 16'(ok), 16'd1);
    @(negedge clk);        // next edge is the boundary edge
    strobe(16'h00C0);
    sb_q.push_back(8);
    check("boundary strobe keeps pending", 16'(pending), 16'd1);
    check_next_frame();
    check("pending held across frame", 16'(pending), 16'd1);
    wait_pending_fall("boundary strobe");
    check_next_frame();

    // Reset in the middle of digit 2 with a word pending.
    wait_an(4'b1110, ok);
    check("reach slot 0 for reset test", 16'(ok), 16'd1);
    strobe(16'h4444);
    wait_an(4'b1011, ok);
    check("reach slot 2 for reset test", 16'(ok), 16'd1);
    check("pending before mid-frame reset", 16'(pending), 16'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid-frame reset an", 16'(an), 16'hF);
    check("mid-frame reset seg", 16'(seg), 16'h7F);
    check("mid-frame reset pending", 16'(pending), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset guard an", 16'(an), 16'hF);
    check("post-reset pending", 16'(pending), 16'd0);
    sb_q.push_back(0);
    check_next_frame();
    sb_q.push_back(0);
    check_next_frame();
    check("discarded word stays discarded", 16'(pending), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
